// File: rtl/divu_seq.sv
// divu_seq: sequential unsigned divider using the restoring algorithm.
// Each RUN cycle produces one quotient bit. A RUN cycle with the step
// counter already at WIDTH registers the result, then one FINISH cycle
// presents it.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high
//   dataA         unsigned dividend (latched at start)
//   dataB         unsigned divisor  (latched at start)
//   SignaltoDIVU  start request, sampled only in IDLE
//   dataOut       {remainder, quotient}, held until the next FINISH
//   done          one-cycle pulse while FINISH presents a new dataOut
//   busy          high in RUN and FINISH
//   divByZero     high with done when the latched divisor was zero
module divu_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   dataA,
    input  logic [WIDTH-1:0]   dataB,
    input  logic               SignaltoDIVU,
    output logic [2*WIDTH-1:0] dataOut,
    output logic               done,
    output logic               busy,
    output logic               divByZero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state, state_nxt;

    // quo starts as the dividend and shifts out its MSB into the remainder
    // while quotient bits shift in at the LSB.
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvsr;
    // After every step the remainder is below the divisor, so WIDTH bits
    // hold it. The shifted value below carries the extra (WIDTH+1)th bit
    // so the compare never overflows.
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             step_ge;
    logic             last;

    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        step_ge = (rem_sh >= {1'b0, dvsr});
        // Only used when step_ge holds, so the result is below dvsr and
        // the dropped top bit is zero.
        rem_sub = rem_sh[WIDTH-1:0] - dvsr;
        last    = (cnt == CW'(WIDTH));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and Moore outputs
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = 1'b0;
        divByZero = 1'b0;
        case (state)
            IDLE: begin
                if (SignaltoDIVU) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last) state_nxt = FINISH;
            end
            FINISH: begin
                busy      = 1'b1;
                done      = 1'b1;
                divByZero = (dvsr == '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            quo     <= '0;
            dvsr    <= '0;
            rem     <= '0;
            cnt     <= '0;
            dataOut <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (SignaltoDIVU) begin
                        quo  <= dataA;
                        dvsr <= dataB;
                        rem  <= '0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    if (!last) begin
                        rem <= step_ge ? rem_sub : rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], step_ge};
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Registered here so it is visible during FINISH.
                        dataOut <= {rem, quo};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_seq.sv
module tb_divu_seq;
    localparam int W      = 32;
    localparam int LAT    = W + 1;  // edges from start-sample edge to done
    localparam int PERIOD = W + 3;  // back-to-back done spacing

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   dataA, dataB;
    logic           SignaltoDIVU;
    logic [2*W-1:0] dataOut;
    logic           done, busy, divByZero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [2*W-1:0] d;
        logic           z;
        int             at;
    } exp_t;
    exp_t sb[$];

    divu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .dataA(dataA), .dataB(dataB),
        .SignaltoDIVU(SignaltoDIVU), .dataOut(dataOut), .done(done),
        .busy(busy), .divByZero(divByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=done expected=none (cyc %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("dataOut", dataOut, e.d);
                chk("divByZero", {{(2*W-1){1'b0}}, divByZero}, {{(2*W-1){1'b0}}, e.z});
                chk("latency_cyc", 64'(cyc), 64'(e.at));
                chk("busy_with_done", {{(2*W-1){1'b0}}, busy}, 64'd1);
            end
        end
    end

    // Called at a negedge with the DUT in IDLE; start is sampled at edge cyc+1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_d, input logic exp_z, input bit expect_done);
        exp_t e;
        dataA = a;
        dataB = b;
        SignaltoDIVU = 1'b1;
        if (expect_done) begin
            e.d = exp_d; e.z = exp_z; e.at = cyc + 1 + LAT;
            sb.push_back(e);
        end
        @(negedge clk);
        SignaltoDIVU = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && sb.size() != 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_dataOut"}, dataOut, '0);
        chk({tag, "_done"}, {{(2*W-1){1'b0}}, done}, '0);
        chk({tag, "_busy"}, {{(2*W-1){1'b0}}, busy}, '0);
        chk({tag, "_divByZero"}, {{(2*W-1){1'b0}}, divByZero}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        reset = 1'b1; SignaltoDIVU = 1'b0; dataA = '0; dataB = '0;
        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 100/7 -> q=14 r=2, done 33 edges after the sampling edge
        issue(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1);
        repeat (5) @(negedge clk);
        chk("busy_mid", {{(2*W-1){1'b0}}, busy}, 64'd1);
        drain(60);
        chk("busy_after", {{(2*W-1){1'b0}}, busy}, 64'd0);

        issue(32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b0, 1);
        drain(60);
        issue(32'd5, 32'd9, {32'd5, 32'd0}, 1'b0, 1);
        drain(60);

        // Divide by zero: all-ones quotient, remainder = dividend
        issue(32'h12345678, 32'd0, {32'h12345678, 32'hFFFFFFFF}, 1'b1, 1);
        drain(60);

        // Inputs and start changed mid-run must be ignored
        issue(32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1);
        repeat (9) @(negedge clk);
        dataA = 32'd55; dataB = 32'd3; SignaltoDIVU = 1'b1;
        @(negedge clk);
        SignaltoDIVU = 1'b0;
        drain(60);
        repeat (45) @(negedge clk);  // monitor flags any second done

        // Reset 15 edges into a division aborts it
        issue(32'd100, 32'd7, '0, 1'b0, 0);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_idle_zero("abort");
        reset = 1'b0;
        @(negedge clk);
        issue(32'd81, 32'd9, {32'd0, 32'd9}, 1'b0, 1);
        drain(60);

        // Start held high: done every PERIOD edges
        dataA = 32'd1000; dataB = 32'd3; SignaltoDIVU = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.d = {32'd1, 32'd333}; e.z = 1'b0; e.at = e0 + k*PERIOD + LAT;
            sb.push_back(e);
        end
        while (cyc < e0 + 2*PERIOD + 1) @(negedge clk);
        SignaltoDIVU = 1'b0;
        drain(200);
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
